alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width.
REQ-002 Parameter LEN_W, default 3: operand-count field width; a transaction carries len+1 operands, 1..2^LEN_W.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  2  per-requester accumulate request, bit i = requester i.
REQ-006 len0, len1  input  LEN_W  operand count minus one, sampled at grant.
REQ-007 data0, data1  input  DATA_W  operand streams.
REQ-008 dvalid  input  2  operand valid, bit i qualifies data_i.
REQ-009 dready  output  2  operand accept; a transfer occurs when dvalid[i] and dready[i] are both high.
REQ-010 gnt  output  2  one-hot grant, held for the whole transaction.
REQ-011 done  output  2  one-cycle pulse to the granted requester when result is valid.
REQ-012 result  output  DATA_W  ALU output; valid in the done cycle and held until the next CLEAR.

Function
REQ-013 The block SHALL sequence one shared ALU instance (A/B registers, wrA/wrB/selA, ALUop zero=0/A=1/B=2/add=3) and tie selA=0.
REQ-014 The FSM SHALL have states IDLE, CLEAR, LOAD, ADD, DONE; the encoding SHALL be an enum.
REQ-015 IDLE: with req!=0, the block SHALL choose the winner via a round-robin pointer, latch its len into the counter limit, set gnt, and go to CLEAR; otherwise it SHALL stay in IDLE with ALUop=A.
REQ-016 Arbitration: if only one req bit is set, that requester wins; if both are set, the pointer's requester wins; after each DONE the pointer SHALL move to the other requester.
REQ-017 CLEAR: wrA=1 and ALUop=zero, so A=0; the next state SHALL be LOAD.
REQ-018 LOAD: dready[g]=1 for granted g only; on dvalid[g], wrB=1 (B<=data_g) and the next state SHALL be ADD; otherwise the FSM stays in LOAD.
REQ-019 ADD: wrA=1 and ALUop=add (A<=A+B), operand counter +1; after the (len+1)th ADD the next state SHALL be DONE, otherwise LOAD.
REQ-020 DONE: ALUop=A, done[g]=1 for one cycle, gnt cleared, pointer toggled, and the next state SHALL be IDLE.
REQ-021 Latency: req sampled at edge k with dvalid held high SHALL give gnt from cycle k+1 and done in cycle k+2+2N, where N=len+1.
REQ-022 Addition SHALL wrap modulo 2^DATA_W; no overflow flag.
REQ-023 dready and done SHALL be 0 for the non-granted requester; its dvalid and data SHALL be ignored.
REQ-024 Deasserting req mid-transaction SHALL NOT abort it; the transaction completes when N operands have been accepted.
REQ-025 A req still high in the DONE cycle SHALL be arbitrated again in the following IDLE cycle, with no back-to-back grant bypassing IDLE.
REQ-026 len changes after grant SHALL be ignored.

Reset
REQ-027 While reset is high, at any state including mid-transaction: state=IDLE, pointer=0, counter=0, gnt=0, done=0, dready=0, ALUop=A, wrA=wrB=0.
REQ-028 The A/B register contents are undefined after reset until the first CLEAR; the result is meaningful only in a done cycle.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the ALUop enum, the FSM state enum, and the DATA_W/LEN_W defaults.
REQ-030 The single sub-module SHALL be the existing ALU; the arbiter, FSM and counter live in alu_share_arbiter.

Verification
REQ-031 Single request: req=01, len0=3, data0=5,6,7,8 with dvalid held -> done=01 at cycle k+10, result=26.
REQ-032 Simultaneous requests after reset: req=11, len0=len1=0, data0=10, data1=20 -> requester 0 served first (result 10), then requester 1 (result 20); gnt never 11.
REQ-033 Backpressure: dvalid0 toggled 1-0-0-1, len0=1, data 3 and 4 -> FSM holds in LOAD while dvalid=0, result=7, done asserted exactly once.
REQ-034 Wrap-around: len0=1, data0=FFFF_FFFF then 2 -> result=1.
REQ-035 Reset mid-ADD with len0=7 -> next cycle gnt=0, dready=0; a new req=10 with len1=0 and data1=9 -> result=9.
REQ-036 Fairness: req=11 held for 4 transactions -> grants alternate 01,10,01,10.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester accumulate arbiter: ALU opcodes, FSM states, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 3;

    typedef enum logic [1:0] {
        ALU_ZERO = 2'd0,
        ALU_A    = 2'd1,
        ALU_B    = 2'd2,
        ALU_ADD  = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Accumulator ALU: A/B registers and a 4-function output (zero, A, B, A+B).
// Latency: output is combinational from A/B; register writes land on the next edge.
// Backpressure: none; the controller decides when to write.
module alu_share_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              wr_a,
    input  logic              wr_b,
    input  logic              sel_a,
    input  alu_op_e           alu_op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    // Function select; the add wraps modulo 2^DATA_W by construction
    always_comb begin
        y = a_q;
        case (alu_op)
            ALU_ZERO: y = '0;
            ALU_A:    y = a_q;
            ALU_B:    y = b_q;
            ALU_ADD:  y = a_q + b_q;
            default:  y = a_q;
        endcase
    end

    // Register write enables; A takes the ALU output unless sel_a picks the input bus
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_a) a_d = sel_a ? din : y;
        if (wr_b) b_d = din;
    end

    // Operand registers carry no reset: contents are established by the CLEAR step
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sequencing one shared ALU to sum len+1 operands.
// Latency: gnt the cycle after req is sampled; done 2+2N cycles after that edge's cycle, N = len+1.
// Backpressure: waits in LOAD with dready high until the granted requester asserts dvalid.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [1:0]        dvalid,
    output logic [1:0]        dready,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] result
);

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              g_q, g_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  lim_q, lim_d;

    alu_op_e           alu_op;
    logic              wr_a, wr_b;
    logic              win;
    logic [DATA_W-1:0] op_dat;
    logic              op_vld;

    // Only the granted requester's stream ever reaches the ALU
    assign op_dat = g_q ? data1 : data0;
    assign op_vld = g_q ? dvalid[1] : dvalid[0];

    // Next-state, arbitration and ALU control; outputs forced idle while reset is held
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        alu_op  = ALU_A;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        dready  = 2'b00;
        done    = 2'b00;
        win     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    win     = (req == 2'b11) ? ptr_q : req[1];
                    g_d     = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    lim_d   = win ? len1 : len0;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                wr_a    = 1'b1;
                alu_op  = ALU_ZERO;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                dready = g_q ? 2'b10 : 2'b01;
                if (op_vld) begin
                    wr_b    = 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                wr_a   = 1'b1;
                alu_op = ALU_ADD;
                if (cnt_q == lim_q) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                done    = gnt_q;
                gnt_d   = 2'b00;
                ptr_d   = ~ptr_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            alu_op = ALU_A;
            wr_a   = 1'b0;
            wr_b   = 1'b0;
            dready = 2'b00;
            done   = 2'b00;
        end
    end

    assign gnt = reset ? 2'b00 : gnt_q;

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            g_q     <= 1'b0;
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
        end
    end

    alu_share_arbiter_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .clk    (clk),
        .wr_a   (wr_a),
        .wr_b   (wr_b),
        .sel_a  (1'b0),
        .alu_op (alu_op),
        .din    (op_dat),
        .y      (result)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of transactions plus hand-written corner sequences.
// Latency: expected done timing is checked against the req cycle.
// Backpressure: operand valid can be gated per cycle from a pattern queue.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = '0;
    logic [LW-1:0] len0 = '0, len1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic [1:0]    dvalid = '0;
    logic [1:0]    dready, gnt, done;
    logic [DW-1:0] result;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
        .data0(data0), .data1(data1), .dvalid(dvalid), .dready(dready),
        .gnt(gnt), .done(done), .result(result)
    );

    typedef struct packed {
        logic [1:0]    who;
        logic [DW-1:0] res;
    } sb_t;

    typedef struct {
        int                  grp;
        int                  who;
        int                  len;
        logic [7:0][DW-1:0]  d;
        logic [DW-1:0]       exp;
    } vec_t;

    vec_t          tbl [11];
    sb_t           sb [$];
    logic [DW-1:0] ops0 [$], ops1 [$];
    int            lens0 [$], lens1 [$];
    int            pend [2];
    bit            vpat0 [$];
    logic [1:0]    gnt_log [$];
    logic [1:0]    gnt_prev = '0;
    int checks = 0, errors = 0, cyc = 0;
    int req_cyc = 0, gnt_cyc = 0, done_cyc = 0, stall0 = 0, done_cnt = 0;

    function automatic vec_t mk(int g, int w, int l, logic [DW-1:0] e,
                                logic [DW-1:0] a0 = 0, logic [DW-1:0] a1 = 0,
                                logic [DW-1:0] a2 = 0, logic [DW-1:0] a3 = 0,
                                logic [DW-1:0] a4 = 0, logic [DW-1:0] a5 = 0,
                                logic [DW-1:0] a6 = 0, logic [DW-1:0] a7 = 0);
        vec_t v;
        v.grp = g; v.who = w; v.len = l; v.exp = e;
        v.d = {a7, a6, a5, a4, a3, a2, a1, a0};
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_txn(int w, int l, logic [7:0][DW-1:0] d, logic [DW-1:0] e);
        sb_t s;
        for (int j = 0; j <= l; j++) begin
            if (w == 0) ops0.push_back(d[j]);
            else        ops1.push_back(d[j]);
        end
        if (w == 0) lens0.push_back(l);
        else        lens1.push_back(l);
        pend[w] = pend[w] + 1;
        s.who = (w == 0) ? 2'b01 : 2'b10;
        s.res = e;
        sb.push_back(s);
    endtask

    // Drive inputs from the bench queues; called just after a rising edge
    task automatic drive();
        bit         v0;
        logic [1:0] nreq;
        v0 = 1'b1;
        if (vpat0.size() > 0) v0 = vpat0.pop_front();
        nreq = {pend[1] > 0, pend[0] > 0};
        if (req == 2'b00 && nreq != 2'b00) req_cyc = cyc;
        req       = nreq;
        len0      = (lens0.size() > 0) ? LW'(lens0[0]) : '0;
        len1      = (lens1.size() > 0) ? LW'(lens1[0]) : '0;
        data0     = (ops0.size() > 0) ? ops0[0] : '0;
        data1     = (ops1.size() > 0) ? ops1[0] : '0;
        dvalid[0] = (ops0.size() > 0) && v0;
        dvalid[1] = (ops1.size() > 0);
    endtask

    // One clock: check outputs at the falling edge, then advance queues after the rising edge
    task automatic step();
        logic [1:0] fire, dn;
        sb_t        e;
        @(negedge clk);
        if (!reset) begin
            chk("gnt_onehot", 64'(gnt[0] & gnt[1]), 64'd0);
            chk("done_in_gnt", 64'(done & ~gnt), 64'd0);
            chk("dready_in_gnt", 64'(dready & ~gnt), 64'd0);
            if (gnt != 2'b00 && gnt_prev == 2'b00) begin
                gnt_log.push_back(gnt);
                gnt_cyc = cyc;
            end
            if (dready[0] && !dvalid[0]) stall0++;
            if (done != 2'b00) begin
                done_cnt++;
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_who", 64'(done), 64'(e.who));
                    chk("result", 64'(result), 64'(e.res));
                end
            end
        end
        gnt_prev = gnt;
        fire = dvalid & dready;
        dn   = done;
        @(posedge clk);
        cyc++;
        #1;
        if (fire[0] && ops0.size() > 0) void'(ops0.pop_front());
        if (fire[1] && ops1.size() > 0) void'(ops1.pop_front());
        if (dn[0] && pend[0] > 0) begin
            pend[0] = pend[0] - 1;
            if (lens0.size() > 0) void'(lens0.pop_front());
        end
        if (dn[1] && pend[1] > 0) begin
            pend[1] = pend[1] - 1;
            if (lens1.size() > 0) void'(lens1.pop_front());
        end
        drive();
    endtask

    task automatic flush();
        ops0.delete(); ops1.delete(); lens0.delete(); lens1.delete();
        sb.delete(); vpat0.delete();
        pend[0] = 0; pend[1] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        drive();
        step();
        step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_dready", 64'(dready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        stall0 = 0;
        done_cnt = 0;
        gnt_log.delete();
    endtask

    task automatic drain(int maxc);
        int n;
        n = 0;
        while ((sb.size() > 0 || pend[0] > 0 || pend[1] > 0) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) chk("drain_timeout", 64'(sb.size()), 64'd0);
        step();
        step();
    endtask

    initial begin
        logic [1:0] alt [4];
        alt[0] = 2'b01; alt[1] = 2'b10; alt[2] = 2'b01; alt[3] = 2'b10;

        tbl[0]  = mk(0, 0, 3, 32'd26, 5, 6, 7, 8);
        tbl[1]  = mk(1, 0, 0, 32'd10, 10);
        tbl[2]  = mk(1, 1, 0, 32'd20, 20);
        tbl[3]  = mk(2, 0, 1, 32'd1, 32'hFFFF_FFFF, 2);
        tbl[4]  = mk(3, 0, 0, 32'd1, 1);
        tbl[5]  = mk(3, 1, 0, 32'd2, 2);
        tbl[6]  = mk(3, 0, 1, 32'd7, 3, 4);
        tbl[7]  = mk(3, 1, 2, 32'd3, 1, 1, 1);
        tbl[8]  = mk(4, 1, 7, 32'd36, 1, 2, 3, 4, 5, 6, 7, 8);
        tbl[9]  = mk(5, 0, 0, 32'd7, 7);
        tbl[10] = mk(5, 1, 2, 32'd600, 100, 200, 300);

        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int i = 0; i < 11; i++)
                if (tbl[i].grp == g) push_txn(tbl[i].who, tbl[i].len, tbl[i].d, tbl[i].exp);
            drain(400);
            if (g == 0) begin
                chk("lat_gnt", 64'(gnt_cyc - req_cyc), 64'd1);
                chk("lat_done", 64'(done_cyc - req_cyc), 64'd10);
                chk("single_done_cnt", 64'(done_cnt), 64'd1);
            end
            if (g == 1) begin
                chk("simul_done_cnt", 64'(done_cnt), 64'd2);
                chk("simul_gnt_cnt", 64'(gnt_log.size()), 64'd2);
                if (gnt_log.size() >= 2) begin
                    chk("simul_first", 64'(gnt_log[0]), 64'(2'b01));
                    chk("simul_second", 64'(gnt_log[1]), 64'(2'b10));
                end
            end
            if (g == 3) begin
                chk("fair_gnt_cnt", 64'(gnt_log.size()), 64'd4);
                for (int i = 0; i < 4; i++)
                    if (i < gnt_log.size()) chk("fair_order", 64'(gnt_log[i]), 64'(alt[i]));
            end
        end

        // Operand backpressure: valid gated low for several LOAD cycles
        do_reset();
        push_txn(0, 1, {192'd0, 32'd4, 32'd3}, 32'd7);
        vpat0.push_back(0); vpat0.push_back(0); vpat0.push_back(0); vpat0.push_back(0);
        vpat0.push_back(1); vpat0.push_back(0); vpat0.push_back(0); vpat0.push_back(1);
        drain(100);
        chk("bp_stalls", 64'(stall0), 64'd3);
        chk("bp_done_cnt", 64'(done_cnt), 64'd1);
        chk("bp_lat_done", 64'(done_cyc - req_cyc), 64'd9);

        // Reset landing on an ADD cycle of a long transaction
        do_reset();
        push_txn(0, 7, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 32'd36);
        sb.delete();
        step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_dready", 64'(dready), 64'd0);
        flush();
        reset = 1'b0;
        drive();
        step();
        chk("midrst_idle_gnt", 64'(gnt), 64'd0);
        chk("midrst_idle_dready", 64'(dready), 64'd0);
        done_cnt = 0;
        push_txn(1, 0, {224'd0, 32'd9}, 32'd9);
        drain(100);
        chk("midrst_done_cnt", 64'(done_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
